addsub_scheduler: RTL and testbench
===================================

ADDSUB_SCHEDULER -- requirements
Module: addsub_scheduler

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning operand/result width in bits.
REQ-002 The block SHALL have parameter R, default 4, meaning number of requesters (power of two, >= 2).
REQ-003 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port req_valid, input, R, per-requester operation request.
REQ-006 The block SHALL have port req_sub, input, R, per-requester mode: 0 = add, 1 = subtract.
REQ-007 The block SHALL have port req_a, input, R*N, packed A operands, requester i at bits [i*N +: N].
REQ-008 The block SHALL have port req_b, input, R*N, packed B operands, same packing as req_a.
REQ-009 The block SHALL have port req_ready, output, R, one-hot accept strobe to the granted requester.
REQ-010 The block SHALL have port rsp_valid, output, 1, result available.
REQ-011 The block SHALL have port rsp_ready, input, 1, consumer accepts result.
REQ-012 The block SHALL have port rsp_id, output, log2(R), index of the requester that owns the result.
REQ-013 The block SHALL have ports rsp_sum (output, N, sum/difference), rsp_cout (output, 1, carry-out; 1 on subtract = no borrow) and rsp_ovf (output, 1, two's-complement overflow).

Function
REQ-014 The FSM SHALL have states IDLE, EXEC, RESP; reset state IDLE.
REQ-015 In IDLE with any req_valid set, the block SHALL, in that cycle, assert req_ready for exactly one winner, latch its A, B, mode and index, and move to EXEC.
REQ-016 In IDLE with no req_valid, req_ready SHALL be all zero and the state SHALL remain IDLE.
REQ-017 Winner selection SHALL be round-robin: the search starts at pointer P and wraps modulo R; P SHALL become winner+1 (mod R) on each accept.
REQ-018 req_ready SHALL be zero in EXEC and RESP; requests held there wait without loss.
REQ-019 In EXEC the block SHALL drive the latched operands through the core, register sum, cout, ovf and id, and move to RESP.
REQ-020 In RESP rsp_valid SHALL be 1 and rsp_* SHALL remain stable until the cycle in which rsp_ready=1, after which the state SHALL be IDLE.
REQ-021 Latency SHALL be: accept at edge t, rsp_valid high from edge t+1 to the rsp_ready handshake; peak throughput SHALL be one operation per 3 cycles.
REQ-022 Add SHALL compute A+B; subtract SHALL compute A+~B+1; results SHALL wrap modulo 2^N.
REQ-023 rsp_ovf SHALL equal carry-into-MSB XOR carry-out of the N-bit sum.
REQ-024 A requester deasserting req_valid before being granted SHALL simply not be granted; no state SHALL be kept for it.

Reset
REQ-025 Asserting rst_n low SHALL immediately force state IDLE, P=0, rsp_valid=0, req_ready=0, and rsp_sum, rsp_cout, rsp_ovf, rsp_id=0.
REQ-026 Reset asserted in EXEC or RESP SHALL discard the in-flight operation; no response for it SHALL ever appear.
REQ-027 Release of rst_n SHALL take effect at the next rising clk edge, and no grant SHALL be issued in the cycle of release.

Structure
REQ-028 A shared package addsub_pkg SHALL hold the FSM state encoding (IDLE=0, EXEC=1, RESP=2) and the mode constants ADD=0, SUB=1.
REQ-029 The arithmetic SHALL be a sub-module addsub_core (parameter N; inputs a, b, sub; outputs sum, cout, ovf), purely combinational and built from a full-adder chain.
REQ-030 The arbiter and FSM SHALL live in addsub_scheduler; addsub_core SHALL be instantiated exactly once.

Verification (N=4, R=4)
REQ-031 Requester 0, sub, A=0010, B=0110 -> rsp_sum=1100, rsp_cout=0, rsp_ovf=0, rsp_id=0, rsp_valid one cycle after accept.
REQ-032 Requester 2, add, A=0110, B=1000 -> rsp_sum=1110, rsp_cout=0, rsp_ovf=0; add A=0111, B=0001 -> rsp_sum=1000, rsp_ovf=1.
REQ-033 All four req_valid held high, rsp_ready=1 -> grant order ids 0,1,2,3,0, one accept every 3 cycles.
REQ-034 rsp_ready held low for 5 cycles in RESP -> rsp_valid and rsp_* stable, req_ready=0 throughout; accept resumes after the handshake.
REQ-035 rst_n pulsed low during EXEC -> all outputs 0 immediately, no response for that op, next grant starts from requester 0.

Source files
------------

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared definitions for the add/subtract scheduler.
//   state_e  - scheduler FSM encoding (IDLE=0, EXEC=1, RESP=2)
//   ADD/SUB  - values of the per-requester mode bit
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

endpackage

// File: rtl/addsub_core.sv
// addsub_core: combinational N-bit adder/subtractor built as a ripple chain
// of full adders.
//   a, b  - operands
//   sub   - mode (ADD: a+b, SUB: a+~b+1)
//   sum   - result modulo 2^N
//   cout  - carry out of the MSB (on subtract, 1 means no borrow)
//   ovf   - two's-complement overflow
module addsub_core
  import addsub_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  logic [N:0]   c;
  logic [N-1:0] b_eff;

  // Subtract is a + ~b with the chain's carry-in supplying the +1.
  assign b_eff = (sub == SUB) ? ~b : b;
  assign c[0]  = (sub == SUB);

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b_eff[i] ^ c[i];
    assign c[i + 1] = (a[i] & b_eff[i]) | (c[i] & (a[i] ^ b_eff[i]));
  end

  assign cout = c[N];
  assign ovf  = c[N] ^ c[N - 1];

endmodule

// File: rtl/addsub_scheduler.sv
// addsub_scheduler: round-robin arbiter in front of one shared add/sub core.
//   clk, rst_n          - clock, asynchronous active-low reset
//   req_valid/req_sub   - per-requester request and mode
//   req_a/req_b         - packed operands, requester i at [i*N +: N]
//   req_ready           - one-hot accept strobe to the winner
//   rsp_valid/rsp_ready - result handshake
//   rsp_id/sum/cout/ovf - owner and result of the current response
//
// state | meaning
// IDLE  | free; grants a winner in the same cycle if any request is up
// EXEC  | latched operands flow through the core; result is registered
// RESP  | rsp_valid high, outputs held until rsp_ready
module addsub_scheduler
  import addsub_pkg::*;
#(
  parameter int N = 4,
  parameter int R = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [R-1:0]         req_valid,
  input  logic [R-1:0]         req_sub,
  input  logic [R*N-1:0]       req_a,
  input  logic [R*N-1:0]       req_b,
  output logic [R-1:0]         req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [$clog2(R)-1:0] rsp_id,
  output logic [N-1:0]         rsp_sum,
  output logic                 rsp_cout,
  output logic                 rsp_ovf
);

  localparam int IW = $clog2(R);

  state_e        state_q;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] id_q;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic          sub_q;
  // Low from reset until the first edge after release, so nothing is
  // granted in the cycle rst_n goes high.
  logic          arm_q;

  logic          any_d;
  logic [IW-1:0] win_d;
  logic          accept_d;

  logic [N-1:0]  core_sum;
  logic          core_cout;
  logic          core_ovf;

  // Round-robin search starting at ptr_q; the IW-bit add wraps modulo R.
  always_comb begin
    any_d = 1'b0;
    win_d = ptr_q;
    for (int k = 0; k < R; k++) begin
      if (!any_d && req_valid[ptr_q + IW'(k)]) begin
        any_d = 1'b1;
        win_d = ptr_q + IW'(k);
      end
    end
  end

  assign accept_d = (state_q == IDLE) && arm_q && any_d;

  always_comb begin
    req_ready = '0;
    if (accept_d) req_ready[win_d] = 1'b1;
  end

  addsub_core #(.N(N)) u_core (
    .a    (a_q),
    .b    (b_q),
    .sub  (sub_q),
    .sum  (core_sum),
    .cout (core_cout),
    .ovf  (core_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= ADD;
      arm_q     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_ovf   <= 1'b0;
    end else begin
      arm_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            a_q     <= req_a[int'(win_d)*N +: N];
            b_q     <= req_b[int'(win_d)*N +: N];
            sub_q   <= req_sub[win_d];
            id_q    <= win_d;
            ptr_q   <= win_d + IW'(1);
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_sum   <= core_sum;
          rsp_cout  <= core_cout;
          rsp_ovf   <= core_ovf;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state_q   <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_scheduler.sv
// tb_addsub_scheduler: directed stimulus with a transaction-level model
// checked every cycle, plus hand-computed literal expectations.
module tb_addsub_scheduler;

  localparam int N = 4;
  localparam int R = 4;
  localparam int M = 1 << N;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [R-1:0]   req_valid = '0;
  logic [R-1:0]   req_sub = '0;
  logic [R*N-1:0] req_a = '0;
  logic [R*N-1:0] req_b = '0;
  logic [R-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [1:0]     rsp_id;
  logic [N-1:0]   rsp_sum;
  logic           rsp_cout;
  logic           rsp_ovf;

  int checks = 0;
  int fails  = 0;

  addsub_scheduler #(.N(N), .R(R)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_sub   (req_sub),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int pick(input int p, input logic [R-1:0] v);
    for (int k = 0; k < R; k++)
      if (v[(p + k) % R]) return (p + k) % R;
    return -1;
  endfunction

  function automatic int to_signed(input int x);
    return (x >= M / 2) ? x - M : x;
  endfunction

  // Plain integer arithmetic: unsigned full result for sum/carry, signed
  // range check for overflow.
  task automatic calc(input int a, input int b, input bit s,
                      output int sum, output int cout, output int ovf);
    int full, r;
    full = s ? a + (M - 1 - b) + 1 : a + b;
    sum  = full % M;
    cout = full / M;
    r    = s ? to_signed(a) - to_signed(b) : to_signed(a) + to_signed(b);
    ovf  = (r > M / 2 - 1 || r < -(M / 2)) ? 1 : 0;
  endtask

  // Transaction stage: 0 free, 1 accepted last edge, 2 response presented.
  int m_stage = 0;
  int m_ptr   = 0;
  bit m_armed = 0;
  int m_sum, m_cout, m_ovf, m_id;

  always @(negedge clk) begin
    logic [R-1:0] exp_ready;
    int w, av, bv;
    if (!rst_n) begin
      m_stage = 0; m_ptr = 0; m_armed = 0;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_sum", rsp_sum, 0);
      chk("rst_rsp_cout", rsp_cout, 0);
      chk("rst_rsp_ovf", rsp_ovf, 0);
      chk("rst_rsp_id", rsp_id, 0);
    end else begin
      exp_ready = '0;
      w = -1;
      if (m_stage == 0 && m_armed) begin
        w = pick(m_ptr, req_valid);
        if (w >= 0) exp_ready[w] = 1'b1;
      end
      chk("mdl_req_ready", req_ready, exp_ready);
      chk("mdl_rsp_valid", rsp_valid, (m_stage == 2));
      if (m_stage == 2) begin
        chk("mdl_rsp_sum", rsp_sum, m_sum);
        chk("mdl_rsp_cout", rsp_cout, m_cout);
        chk("mdl_rsp_ovf", rsp_ovf, m_ovf);
        chk("mdl_rsp_id", rsp_id, m_id);
      end
      case (m_stage)
        0: if (w >= 0) begin
          av = int'(req_a[w*N +: N]);
          bv = int'(req_b[w*N +: N]);
          calc(av, bv, req_sub[w], m_sum, m_cout, m_ovf);
          m_id    = w;
          m_ptr   = (w + 1) % R;
          m_stage = 1;
        end
        1: m_stage = 2;
        default: if (rsp_ready) m_stage = 0;
      endcase
      m_armed = 1;
    end
  end

  // ---------------- directed helpers ----------------
  task automatic set_op(input int id, input bit s, input int a, input int b);
    req_sub[id]       = s;
    req_a[id*N +: N]  = a[N-1:0];
    req_b[id*N +: N]  = b[N-1:0];
  endtask

  task automatic wait_grant(input int id, output bit got);
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1;
    end
    chk("grant_seen", got, 1);
  endtask

  task automatic do_op(input int id, input bit s, input int a, input int b,
                       input int es, input int ec, input int eo);
    bit got;
    @(posedge clk); #1;
    set_op(id, s, a, b);
    req_valid = '0;
    req_valid[id] = 1'b1;
    wait_grant(id, got);
    if (got) begin
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
      @(negedge clk);
      chk("lat_exec_idle", rsp_valid, 0);
      @(negedge clk);
      chk("lat_resp_valid", rsp_valid, 1);
      chk("lit_sum", rsp_sum, es);
      chk("lit_cout", rsp_cout, ec);
      chk("lit_ovf", rsp_ovf, eo);
      chk("lit_id", rsp_id, id);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int gid[5];
    int gcyc[5];
    int ng, cyc;
    bit got;
    int exp_ids[5];
    exp_ids = '{0, 1, 2, 3, 0};

    // Reset held for a few cycles; the model checks all-zero outputs.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic operations (pointer path: 0 -> 1 -> 3 -> 3 -> 2 -> 0).
    do_op(0, 1'b1, 4'b0010, 4'b0110, 4'b1100, 0, 0);
    do_op(2, 1'b0, 4'b0110, 4'b1000, 4'b1110, 0, 0);
    do_op(2, 1'b0, 4'b0111, 4'b0001, 4'b1000, 0, 1);
    do_op(1, 1'b1, 4'b0101, 4'b0101, 4'b0000, 1, 0);
    do_op(3, 1'b1, 4'b1000, 4'b0001, 4'b0111, 1, 1);

    // All requesters continuously valid.
    @(posedge clk); #1;
    for (int i = 0; i < R; i++) set_op(i, i[0], i + 5, i + 1);
    rsp_ready = 1'b1;
    req_valid = '1;
    ng = 0; cyc = 0;
    while (ng < 5 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (|req_ready) begin
        for (int i = 0; i < R; i++) if (req_ready[i]) gid[ng] = i;
        gcyc[ng] = cyc;
        ng++;
      end
    end
    chk("stream_grants", ng, 5);
    for (int k = 0; k < ng; k++) begin
      chk("stream_order", gid[k], exp_ids[k]);
      if (k > 0) chk("stream_spacing", gcyc[k] - gcyc[k-1], 3);
    end
    @(posedge clk); #1;
    req_valid = '0;
    idle_cycles(4);

    // Consumer back-pressure in RESP.
    rsp_ready = 1'b0;
    set_op(1, 1'b0, 3, 4);
    set_op(0, 1'b1, 1, 1);
    req_valid = 4'b0011;
    wait_grant(1, got);
    if (got) begin
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      @(negedge clk);
      repeat (6) begin
        @(negedge clk);
        chk("hold_valid", rsp_valid, 1);
        chk("hold_sum", rsp_sum, 7);
        chk("hold_id", rsp_id, 1);
        chk("hold_ready_low", req_ready, 0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("resume_grant", req_ready, 4'b0001);
    end
    @(posedge clk); #1;
    req_valid = '0;
    idle_cycles(4);

    // Reset during EXEC discards the op and restarts the pointer at 0.
    set_op(1, 1'b0, 2, 2);
    req_valid = 4'b0010;
    wait_grant(1, got);
    @(posedge clk); #2;
    rst_n = 1'b0;
    req_valid = '1;
    #1;
    chk("async_rst_valid", rsp_valid, 0);
    chk("async_rst_ready", req_ready, 0);
    chk("async_rst_sum", rsp_sum, 0);
    chk("async_rst_id", rsp_id, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("release_no_grant", req_ready, 0);
    @(negedge clk);
    chk("post_rst_grant", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    idle_cycles(5);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
